// File: rtl/uart_tx_cfg_if.sv
// Parallel-side and line-side signals of the configurable UART transmitter.
interface uart_tx_cfg_if #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
);
    logic                      DATA_VALID;
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic                      STOP_2;
    logic [PRESCALE_WIDTH-1:0] PRESCALE;
    logic                      TX_OUT;
    logic                      BUSY;
    logic                      FRAME_DONE;

    modport master (
        output DATA_VALID, P_DATA, PAR_EN, PAR_TYP, STOP_2, PRESCALE,
        input  TX_OUT, BUSY, FRAME_DONE
    );

    modport slave (
        input  DATA_VALID, P_DATA, PAR_EN, PAR_TYP, STOP_2, PRESCALE,
        output TX_OUT, BUSY, FRAME_DONE
    );
endinterface

// File: rtl/uart_tx_cfg.sv
// UART transmitter with configurable data width, per-bit prescaler, optional parity
// and optional second stop bit. All outputs come straight from flops.
module uart_tx_cfg #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic          CLK,
    input  logic          RST,
    uart_tx_cfg_if.slave  bus
);
    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    state_t                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic [PRESCALE_WIDTH-1:0] plast_q, plast_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      par_en_q, par_en_d;
    logic                      par_q, par_d;
    logic                      stop2_q, stop2_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      bit_end;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Counters, shadow registers and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q    <= '0;
            plast_q  <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            stop2_q  <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            plast_q  <= plast_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            stop2_q  <= stop2_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next state, counters and next output values
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        plast_d  = plast_q;
        idx_d    = idx_q;
        data_d   = data_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        stop2_d  = stop2_q;
        done_d   = 1'b0;
        tx_d     = 1'b1;
        bit_end  = (cnt_q == plast_q);

        if (state_q == S_IDLE) begin
            if (bus.DATA_VALID) begin
                data_d   = bus.P_DATA;
                par_en_d = bus.PAR_EN;
                par_d    = (^bus.P_DATA) ^ bus.PAR_TYP;
                stop2_d  = bus.STOP_2;
                // A prescale of zero behaves as one cycle per bit
                plast_d  = (bus.PRESCALE == '0) ? '0
                                                : bus.PRESCALE - PRESCALE_WIDTH'(1);
                cnt_d    = '0;
                idx_d    = '0;
                state_d  = S_START;
            end
        end else if (!bit_end) begin
            cnt_d = cnt_q + PRESCALE_WIDTH'(1);
        end else begin
            cnt_d = '0;
            case (state_q)
                S_START: begin
                    idx_d   = '0;
                    state_d = S_DATA;
                end
                S_DATA: begin
                    if (idx_q == IDX_W'(DATA_WIDTH - 1))
                        state_d = par_en_q ? S_PARITY : S_STOP1;
                    else
                        idx_d = idx_q + IDX_W'(1);
                end
                S_PARITY: state_d = S_STOP1;
                S_STOP1: begin
                    state_d = stop2_q ? S_STOP2 : S_IDLE;
                    done_d  = !stop2_q;
                end
                S_STOP2: begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Line level for the coming cycle, decoded from the next state
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_d[idx_d];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign bus.TX_OUT     = tx_q;
    assign bus.BUSY       = busy_q;
    assign bus.FRAME_DONE = done_q;
endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, successor to the fixed 8-bit TX. Adds configurable data width, an internal per-bit prescaler, optional two stop bits, a frame-done pulse and a clean accept rule. It serialises one parallel word per frame onto TX_OUT (LSB first) and sits between the system-side register/FIFO logic and the UART line. Start bit, parity and stop bits are generated internally.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9 supported)
PRESCALE_WIDTH, 6, width of PRESCALE port (clock cycles per bit)

Ports:
CLK  input  1  single clock, all logic rising-edge
RST  input  1  synchronous, active-high reset
DATA_VALID  input  1  word on P_DATA valid; accepted only when BUSY=0
P_DATA  input  DATA_WIDTH  parallel word to transmit
PAR_EN  input  1  1 = append parity bit
PAR_TYP  input  1  0 = even, 1 = odd parity
STOP_2  input  1  1 = two stop bits, 0 = one
PRESCALE  input  PRESCALE_WIDTH  CLK cycles per bit; 0 treated as 1
TX_OUT  output  1  serial line, idle high, registered
BUSY  output  1  high while a frame is in progress, registered
FRAME_DONE  output  1  one-cycle pulse after the last stop bit completes

Behaviour:
- Reset (RST=1 at an edge): state IDLE, TX_OUT=1, BUSY=0, FRAME_DONE=0, counters cleared. Reset mid-frame aborts the frame; the line returns high at the next edge with no partial stop bit; the aborted word is lost.
- Accept: at an edge with DATA_VALID=1 and BUSY=0 (state IDLE), latch P_DATA, PAR_EN, PAR_TYP, STOP_2 and PRESCALE into shadow registers. Later changes to the inputs do not affect the current frame. DATA_VALID while BUSY=1 is ignored, with no queueing.
- Latency: accept at edge k -> TX_OUT=0 (start) and BUSY=1 visible after edge k.
- States: IDLE -> START -> DATA -> PARITY (only if PAR_EN latched) -> STOP1 -> STOP2 (only if STOP_2 latched) -> IDLE.
- Each non-IDLE state lasts exactly P cycles, where P = latched PRESCALE, or 1 if the latched value is 0. A bit counter (0..P-1) advances the state when it reaches P-1.
- DATA: DATA_WIDTH bits, bit 0 first. A bit index counter (0..DATA_WIDTH-1) advances every P cycles.
- Parity: computed from the latched word at accept. Bit = XOR of data bits for even; inverted XOR for odd.
- STOP bits drive TX_OUT=1.
- Frame length = P*(1 + DATA_WIDTH + PAR_EN + 1 + STOP_2) cycles.
- End of frame: on the edge ending the final stop bit, state goes to IDLE, BUSY=0 and FRAME_DONE=1 for exactly one cycle. A DATA_VALID sampled in that same IDLE cycle is accepted, so the minimum inter-frame gap is one idle cycle at TX_OUT=1.
- BUSY=1 exactly while state != IDLE.
- TX_OUT never glitches: it is driven from a flop, not a mux of flops.
- In IDLE, TX_OUT=1 regardless of any input.

Test Plan:
- Basic 8N1: PRESCALE=1, PAR_EN=0, STOP_2=0, P_DATA=0xA5, pulse DATA_VALID -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1. BUSY high 10 cycles, then FRAME_DONE single pulse.
- Parity even/odd: P_DATA=0x07, PAR_EN=1. PAR_TYP=0 -> parity bit 1. PAR_TYP=1 -> parity bit 0. Frame is 11 bits with parity after bit 7.
- Prescale + 2 stop: PRESCALE=4, STOP_2=1, PAR_EN=1, P_DATA=0x3C -> each bit held 4 cycles, BUSY high 48 cycles. PRESCALE=0 -> behaves as 1.
- Input change/ignore: change P_DATA, PRESCALE and PAR_TYP mid-frame and assert DATA_VALID while BUSY -> current frame unchanged, no second frame starts.
- Back-to-back: DATA_VALID held high with 0x55 then 0xAA -> second start bit begins exactly one idle cycle (TX_OUT=1) after FRAME_DONE.
- Reset mid-frame: assert RST during bit 3 of 0xFF -> next edge TX_OUT=1, BUSY=0, no FRAME_DONE. A new DATA_VALID after RST release transmits normally.
